// File: rtl/bitonic_merge.sv
// bitonic_merge: pipelined bitonic merger, log_N registered compare-exchange stages, one vector per clock
module bitonic_merge #(
  parameter int N           = 16,
  parameter int INPUT_WIDTH = 6,
  parameter int log_N       = $clog2(N),
  parameter bit polarity    = 1'b0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [0:N*INPUT_WIDTH-1] in,
  output logic [0:N*INPUT_WIDTH-1] out
);
  logic [INPUT_WIDTH-1:0] src  [log_N][N];
  logic [INPUT_WIDTH-1:0] nxt  [log_N][N];
  logic [INPUT_WIDTH-1:0] pipe [log_N][N];
  for (genvar s = 0; s < log_N; s++) begin : g_s
    localparam int D = N >> (s + 1);
    for (genvar i = 0; i < N; i++) begin : g_i
      if (s == 0) begin : g_in
        assign src[s][i] = in[i*INPUT_WIDTH +: INPUT_WIDTH];
      end else begin : g_pipe
        assign src[s][i] = pipe[s-1][i];
      end
      // the lower key of each pair owns both outputs; equal keys stay put
      if ((i % (2 * D)) < D) begin : g_cx
        logic swap;
        assign swap        = polarity ? (src[s][i] < src[s][i+D]) : (src[s][i] > src[s][i+D]);
        assign nxt[s][i]   = swap ? src[s][i+D] : src[s][i];
        assign nxt[s][i+D] = swap ? src[s][i] : src[s][i+D];
      end
    end
  end
  for (genvar i = 0; i < N; i++) begin : g_o
    assign out[i*INPUT_WIDTH +: INPUT_WIDTH] = pipe[log_N-1][i];
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int s = 0; s < log_N; s++)
        for (int i = 0; i < N; i++)
          pipe[s][i] <= '0;
    end else begin
      pipe <= nxt;
    end
endmodule

// File: tb/tb_bitonic_merge.sv
// tb_bitonic_merge: randomized and directed checks of ascending/descending mergers at N=16 and N=2
module tb_bitonic_merge;
  localparam int W = 6;
  localparam int L16 = 4;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [0:16*W-1] in16, out16a, out16d;
  logic [0:2*W-1] in2, out2a, out2d;
  logic [0:16*W-1] q16a[$], q16d[$];
  logic [0:2*W-1] q2a[$], q2d[$];
  int vectors = 0;
  int fails = 0;

  always #5 clk = ~clk;

  bitonic_merge #(.N(16), .INPUT_WIDTH(W), .log_N(4), .polarity(1'b0)) u16a (.clk(clk), .reset(reset), .in(in16), .out(out16a));
  bitonic_merge #(.N(16), .INPUT_WIDTH(W), .log_N(4), .polarity(1'b1)) u16d (.clk(clk), .reset(reset), .in(in16), .out(out16d));
  bitonic_merge #(.N(2), .INPUT_WIDTH(W), .log_N(1), .polarity(1'b0)) u2a (.clk(clk), .reset(reset), .in(in2), .out(out2a));
  bitonic_merge #(.N(2), .INPUT_WIDTH(W), .log_N(1), .polarity(1'b1)) u2d (.clk(clk), .reset(reset), .in(in2), .out(out2d));

  // reference: a bitonic input merges to its plain sorted order
  function automatic logic [0:16*W-1] sort16(input logic [0:16*W-1] v, input bit desc);
    int k[16];
    logic [0:16*W-1] r;
    for (int i = 0; i < 16; i++) k[i] = int'(v[i*W +: W]);
    for (int i = 1; i < 16; i++)
      for (int j = i; j > 0; j--)
        if (desc ? (k[j] > k[j-1]) : (k[j] < k[j-1])) begin
          int t;
          t = k[j]; k[j] = k[j-1]; k[j-1] = t;
        end
    for (int i = 0; i < 16; i++) r[i*W +: W] = k[i][W-1:0];
    return r;
  endfunction

  function automatic logic [0:2*W-1] sort2(input logic [0:2*W-1] v, input bit desc);
    logic [W-1:0] a, b, lo, hi;
    a = v[0:W-1];
    b = v[W:2*W-1];
    lo = (a < b) ? a : b;
    hi = (a < b) ? b : a;
    return desc ? {hi, lo} : {lo, hi};
  endfunction

  // random up-then-down sequence, cyclically rotated (still bitonic)
  function automatic logic [0:16*W-1] rand_bitonic();
    logic [0:16*W-1] v, srt, r;
    int s[16];
    int f, b, rot;
    for (int i = 0; i < 16; i++) v[i*W +: W] = W'($urandom_range(63));
    srt = sort16(v, 1'b0);
    f = 0;
    b = 15;
    for (int i = 0; i < 16; i++)
      if ($urandom_range(1) == 1) begin
        s[f] = int'(srt[i*W +: W]); f++;
      end else begin
        s[b] = int'(srt[i*W +: W]); b--;
      end
    rot = int'($urandom_range(15));
    for (int i = 0; i < 16; i++) r[((i + rot) % 16)*W +: W] = s[i][W-1:0];
    return r;
  endfunction

  task automatic chk16(input string tag, input logic [0:16*W-1] got, input logic [0:16*W-1] exp);
    vectors++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic chk2(input string tag, input logic [0:2*W-1] got, input logic [0:2*W-1] exp);
    vectors++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk16({tag, "_16a"}, out16a, '0);
    chk16({tag, "_16d"}, out16d, '0);
    chk2({tag, "_2a"}, out2a, '0);
    chk2({tag, "_2d"}, out2d, '0);
  endtask

  // called at a negedge: drive, clock once, compare at the following negedge
  task automatic step(input logic [0:16*W-1] a, input logic [0:2*W-1] b);
    in16 = a;
    in2 = b;
    q16a.push_back(sort16(a, 1'b0));
    q16d.push_back(sort16(a, 1'b1));
    q2a.push_back(sort2(b, 1'b0));
    q2d.push_back(sort2(b, 1'b1));
    @(posedge clk);
    @(negedge clk);
    chk16("stream_16a", out16a, q16a.pop_front());
    chk16("stream_16d", out16d, q16d.pop_front());
    chk2("stream_2a", out2a, q2a.pop_front());
    chk2("stream_2d", out2d, q2d.pop_front());
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    #1 chk_zero("reset_async");
    @(posedge clk);
    #1 chk_zero("reset_held");
    in16 = '0;
    in2 = '0;
    @(negedge clk);
    #2 reset = 1'b0;
    q16a.delete(); q16d.delete(); q2a.delete(); q2d.delete();
    for (int i = 0; i < L16 - 1; i++) begin
      q16a.push_back('0);
      q16d.push_back('0);
    end
    @(negedge clk);
  endtask

  initial begin
    logic [0:16*W-1] spec_v, ramp, rramp, hi_lo, lo_hi;
    for (int i = 0; i < 16; i++) begin
      spec_v[i*W +: W] = W'((i < 8) ? (2 * i + 1) : (2 * (15 - i)));
      ramp[i*W +: W] = W'(i);
      rramp[i*W +: W] = W'(15 - i);
      hi_lo[i*W +: W] = (i < 8) ? 6'd63 : 6'd0;
      lo_hi[i*W +: W] = (i < 8) ? 6'd0 : 6'd63;
    end
    in16 = '0;
    in2 = '0;
    do_reset();
    step(spec_v, {6'd5, 6'd3});
    chk2("n2_asc", out2a, {6'd3, 6'd5});
    chk2("n2_desc", out2d, {6'd5, 6'd3});
    step(hi_lo, {6'd3, 6'd5});
    chk2("n2_asc_sorted", out2a, {6'd3, 6'd5});
    step(lo_hi, {6'd63, 6'd63});
    step(rand_bitonic(), {6'd0, 6'd63});
    chk16("spec_asc", out16a, ramp);
    chk16("spec_desc", out16d, rramp);
    step(rand_bitonic(), {6'd7, 6'd7});
    chk16("dup_hi_lo", out16a, lo_hi);
    step(rand_bitonic(), W'($urandom_range(63)) << W | W'($urandom_range(63)));
    chk16("dup_lo_hi", out16a, lo_hi);
    chk16("dup_lo_hi_desc", out16d, hi_lo);
    for (int n = 0; n < 40; n++)
      step(rand_bitonic(), {W'($urandom_range(63)), W'($urandom_range(63))});
    do_reset();
    for (int n = 0; n < 12; n++)
      step(rand_bitonic(), {W'($urandom_range(63)), W'($urandom_range(63))});
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
